hp48_bus_master: RTL and testbench

- CPU-side initiator for the HP48 nibble-serial bus; the counterpart of the bus manager that decodes address/command and returns one nibble per strobe.
- Accepts a single multi-nibble read or write request (1-16 nibbles) from the Saturn core.
- Sequences it into per-strobe bus commands with an auto-incrementing 20-bit address.
- Returns read data packed little-endian (least-significant nibble first) with a one-cycle response pulse.

---
 rtl/hp48_bus_master_pkg.sv | 21 ++
 rtl/hp48_bus_master_addr_gen.sv | 42 ++++
 rtl/hp48_bus_master.sv | 133 +++++++++++++
 tb/tb_hp48_bus_master.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/hp48_bus_master_pkg.sv
// hp48_bus_master_pkg: shared HP48 bus command encodings, bus master state
// encodings and the default bus address width.
package hp48_bus_master_pkg;

    localparam int ADDR_W = 20;

    // Bus manager command encodings
    localparam logic [3:0] CMD_NOP      = 4'd0;
    localparam logic [3:0] CMD_PC_READ  = 4'd1;
    localparam logic [3:0] CMD_DP_READ  = 4'd2;
    localparam logic [3:0] CMD_DP_WRITE = 4'd3;
    localparam logic [3:0] CMD_LOAD_PC  = 4'd4;
    localparam logic [3:0] CMD_LOAD_DP  = 4'd5;

    // Bus master FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_XFER = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/hp48_bus_master_addr_gen.sv
// hp48_bus_master_addr_gen: wrapping nibble address and nibble-index counter
// with a terminal-count flag (index equals the latched last index).
module hp48_bus_master_addr_gen #(
    parameter int ADDR_W = 20,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [IDX_W-1:0]  last_index,
    output logic [ADDR_W-1:0] addr,
    output logic [IDX_W-1:0]  index,
    output logic              terminal
);

    logic [IDX_W-1:0] last_q;

    // Load the start point, then step address and index together; the
    // address wraps naturally at 2^ADDR_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr   <= '0;
            index  <= '0;
            last_q <= '0;
        end else if (load) begin
            addr   <= start_addr;
            index  <= '0;
            last_q <= last_index;
        end else if (advance) begin
            addr  <= addr + ADDR_W'(1);
            index <= index + IDX_W'(1);
        end
    end

    // Terminal count: current nibble is the last one of the request
    always_comb begin
        terminal = (index == last_q);
    end

endmodule

// File: rtl/hp48_bus_master.sv
// hp48_bus_master: CPU-side initiator for the HP48 nibble-serial bus.
// Turns one 1..MAX_NIBS nibble read/write request into LOAD_DP plus
// DP_READ/DP_WRITE strobes and returns read data little-endian.
// Build option: HP48_BUS_MASTER_LOAD_CYCLE_EN inserts the LOAD_DP cycle;
// without it IDLE goes straight to XFER and the responder follows
// bus_address on every cycle.
module hp48_bus_master #(
    parameter int ADDR_W   = hp48_bus_master_pkg::ADDR_W,
    parameter int MAX_NIBS = 16
) (
    input  logic                          strobe,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_write,
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic [$clog2(MAX_NIBS)-1:0]   req_count,
    input  logic [4*MAX_NIBS-1:0]         req_data,
    output logic [ADDR_W-1:0]             bus_address,
    output logic [3:0]                    bus_command,
    output logic [3:0]                    bus_nibble_out,
    input  logic [3:0]                    bus_nibble_in,
    input  logic                          bus_error,
    output logic                          rsp_valid,
    output logic [4*MAX_NIBS-1:0]         rsp_data,
    output logic                          rsp_error,
    output logic                          busy
);

    import hp48_bus_master_pkg::*;

    localparam int IDX_W = $clog2(MAX_NIBS);

    logic [1:0]            state;
    logic                  write_q;
    logic [4*MAX_NIBS-1:0] data_q;
    logic [ADDR_W-1:0]     cur_addr;
    logic [IDX_W-1:0]      index;
    logic                  terminal;
    logic                  accept;
    logic                  advance;

    always_comb begin
        accept  = (state == ST_IDLE) && req_valid;
        advance = (state == ST_XFER) && !bus_error && !terminal;
    end

    hp48_bus_master_addr_gen #(
        .ADDR_W (ADDR_W),
        .IDX_W  (IDX_W)
    ) u_addr_gen (
        .clk        (strobe),
        .reset      (reset),
        .load       (accept),
        .advance    (advance),
        .start_addr (req_addr),
        .last_index (req_count),
        .addr       (cur_addr),
        .index      (index),
        .terminal   (terminal)
    );

    // Request sequencing FSM, request latching and read-data capture
    always_ff @(posedge strobe) begin
        if (reset) begin
            state     <= ST_IDLE;
            write_q   <= 1'b0;
            data_q    <= '0;
            rsp_data  <= '0;
            rsp_error <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        write_q   <= req_write;
                        data_q    <= req_data;
                        rsp_data  <= '0;
                        rsp_error <= 1'b0;
`ifdef HP48_BUS_MASTER_LOAD_CYCLE_EN
                        state     <= ST_LOAD;
`else
                        state     <= ST_XFER;
`endif
                    end
                end
                ST_LOAD: state <= ST_XFER;
                ST_XFER: begin
                    if (bus_error) begin
                        rsp_error <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        if (!write_q)
                            rsp_data[{index, 2'b00} +: 4] <= bus_nibble_in;
                        if (terminal)
                            state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Moore outputs decoded from the current state
    always_comb begin
        req_ready      = 1'b0;
        busy           = 1'b1;
        rsp_valid      = 1'b0;
        bus_command    = CMD_NOP;
        bus_address    = '0;
        bus_nibble_out = '0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            ST_LOAD: begin
                bus_command = CMD_LOAD_DP;
                bus_address = cur_addr;
            end
            ST_XFER: begin
                bus_address = cur_addr;
                if (write_q) begin
                    bus_command    = CMD_DP_WRITE;
                    bus_nibble_out = data_q[{index, 2'b00} +: 4];
                end else begin
                    bus_command = CMD_DP_READ;
                end
            end
            default: rsp_valid = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_hp48_bus_master.sv
// tb_hp48_bus_master: table-driven directed bench for hp48_bus_master with
// a responder returning nibble = bus_address[3:0], plus a mid-transfer
// reset sequence.
module tb_hp48_bus_master;

    import hp48_bus_master_pkg::*;

`ifdef HP48_BUS_MASTER_LOAD_CYCLE_EN
    localparam int LOAD_CYC = 1;
`else
    localparam int LOAD_CYC = 0;
`endif

    logic        strobe = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [19:0] req_addr;
    logic [3:0]  req_count;
    logic [63:0] req_data;
    logic [19:0] bus_address;
    logic [3:0]  bus_command;
    logic [3:0]  bus_nibble_out;
    logic [3:0]  bus_nibble_in;
    logic        bus_error;
    logic        rsp_valid;
    logic [63:0] rsp_data;
    logic        rsp_error;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    hp48_bus_master #(
        .ADDR_W   (20),
        .MAX_NIBS (16)
    ) dut (
        .strobe         (strobe),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_count      (req_count),
        .req_data       (req_data),
        .bus_address    (bus_address),
        .bus_command    (bus_command),
        .bus_nibble_out (bus_nibble_out),
        .bus_nibble_in  (bus_nibble_in),
        .bus_error      (bus_error),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .rsp_error      (rsp_error),
        .busy           (busy)
    );

    always #5 strobe = ~strobe;

    // Responder memory model: each location holds its own low address nibble
    assign bus_nibble_in = bus_address[3:0];

    typedef struct {
        logic        wr;
        logic [19:0] addr;
        logic [3:0]  cnt;
        logic [63:0] data;
        int          err_at;   // XFER index with bus_error high, -1 = none
        logic [63:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_txn(input int id, input vec_t v);
        int          nx;
        logic [19:0] a;
        logic [63:0] sh;
        nx = (v.err_at >= 0) ? v.err_at + 1 : int'(v.cnt) + 1;
        @(negedge strobe);
        chk($sformatf("v%0d idle ready", id), {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_write = v.wr;
        req_addr  = v.addr;
        req_count = v.cnt;
        req_data  = v.data;
        @(negedge strobe);
        // Scramble request fields to prove they were latched at accept
        req_valid = 1'b0;
        req_write = ~v.wr;
        req_addr  = 20'h5A5A5;
        req_count = 4'hF;
        req_data  = 64'hDEAD_BEEF_0BAD_F00D;
        if (LOAD_CYC == 1) begin
            chk($sformatf("v%0d load cmd", id), {60'd0, bus_command}, {60'd0, CMD_LOAD_DP});
            chk($sformatf("v%0d load addr", id), {44'd0, bus_address}, {44'd0, v.addr});
            @(negedge strobe);
        end
        for (int i = 0; i < nx; i++) begin
            a  = v.addr + 20'(i);
            sh = v.data >> (4 * i);
            bus_error = (i == v.err_at);
            chk($sformatf("v%0d x%0d cmd", id, i), {60'd0, bus_command},
                {60'd0, v.wr ? CMD_DP_WRITE : CMD_DP_READ});
            chk($sformatf("v%0d x%0d addr", id, i), {44'd0, bus_address}, {44'd0, a});
            if (v.wr)
                chk($sformatf("v%0d x%0d wnib", id, i), {60'd0, bus_nibble_out}, {60'd0, sh[3:0]});
            chk($sformatf("v%0d x%0d rsp_valid", id, i), {63'd0, rsp_valid}, 64'd0);
            @(negedge strobe);
            bus_error = 1'b0;
        end
        // DONE cycle: accept + N + LOAD_CYC + 1
        chk($sformatf("v%0d done rsp_valid", id), {63'd0, rsp_valid}, 64'd1);
        chk($sformatf("v%0d done cmd", id), {60'd0, bus_command}, {60'd0, CMD_NOP});
        chk($sformatf("v%0d done ready", id), {63'd0, req_ready}, 64'd0);
        chk($sformatf("v%0d rsp_data", id), rsp_data, v.exp_data);
        chk($sformatf("v%0d rsp_error", id), {63'd0, rsp_error}, {63'd0, v.exp_err});
        @(negedge strobe);
        chk($sformatf("v%0d post rsp_valid", id), {63'd0, rsp_valid}, 64'd0);
        chk($sformatf("v%0d post busy", id), {63'd0, busy}, 64'd0);
        chk($sformatf("v%0d hold rsp_data", id), rsp_data, v.exp_data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 20'h00100, 4'd4,  64'd0,                  -1, 64'h0000000000043210, 1'b0};
        vecs[1] = '{1'b1, 20'h7FFF8, 4'd15, 64'hFEDCBA9876543210,   -1, 64'h0,                1'b0};
        vecs[2] = '{1'b0, 20'hFFFFF, 4'd2,  64'd0,                  -1, 64'h000000000000010F, 1'b0};
        vecs[3] = '{1'b0, 20'h00020, 4'd7,  64'd0,                   2, 64'h0000000000000010, 1'b1};
        vecs[4] = '{1'b0, 20'h00010, 4'd0,  64'd0,                  -1, 64'h0,                1'b0};
        vecs[5] = '{1'b0, 20'h00000, 4'd15, 64'd0,                  -1, 64'hFEDCBA9876543210, 1'b0};
        vecs[6] = '{1'b1, 20'h12345, 4'd3,  64'h000000000000ABCD,    0, 64'h0,                1'b1};

        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_count = '0;
        req_data  = '0;
        bus_error = 1'b0;
        repeat (2) @(negedge strobe);
        chk("reset req_ready", {63'd0, req_ready}, 64'd1);
        chk("reset bus_command", {60'd0, bus_command}, {60'd0, CMD_NOP});
        chk("reset bus_address", {44'd0, bus_address}, 64'd0);
        chk("reset bus_nibble_out", {60'd0, bus_nibble_out}, 64'd0);
        chk("reset rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("reset rsp_data", rsp_data, 64'd0);
        chk("reset rsp_error", {63'd0, rsp_error}, 64'd0);
        chk("reset busy", {63'd0, busy}, 64'd0);
        reset = 1'b0;

        for (int k = 0; k < 7; k++)
            run_txn(k, vecs[k]);

        // Reset on the 2nd XFER cycle of an 8-nibble read
        @(negedge strobe);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 20'h00040;
        req_count = 4'd7;
        @(negedge strobe);
        req_valid = 1'b0;
        repeat (LOAD_CYC + 1) @(negedge strobe);
        chk("rst 2nd xfer cmd", {60'd0, bus_command}, {60'd0, CMD_DP_READ});
        chk("rst 2nd xfer addr", {44'd0, bus_address}, 64'h41);
        reset = 1'b1;
        @(negedge strobe);
        reset = 1'b0;
        chk("rst cmd nop", {60'd0, bus_command}, {60'd0, CMD_NOP});
        chk("rst ready", {63'd0, req_ready}, 64'd1);
        chk("rst busy", {63'd0, busy}, 64'd0);
        for (int c = 0; c < 12; c++) begin
            chk($sformatf("rst no rsp c%0d", c), {63'd0, rsp_valid}, 64'd0);
            @(negedge strobe);
        end

        // Normal request after the aborted one
        run_txn(7, vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
